fifo_sync_param: RTL and testbench

- Single-clock, parametrised successor to the team's 8-bit synchronous FIFO.
- Adds generic data width and depth, programmable almost-full/almost-empty thresholds, an occupancy count, sticky-free overflow/underflow pulses, and a first-word-fall-through (FWFT) mode.
- Sits between protocol front-ends (Xillybus-style streams) and packet-processing logic as the standard elastic buffer.

---
 rtl/fifo_sync_param_if.sv | 42 ++++
 rtl/fifo_sync_param.sv | 129 ++++++++++++
 tb/tb_fifo_sync_param.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_sync_param_if.sv
// Bundle of data and status signals between a FIFO and its producer/consumer.
//
// Handshake semantics:
//   write side - a word on din is taken at a rising clk edge when wr_en=1 and
//                full=0; wr_en while full is dropped and reported by a
//                one-cycle overflow pulse after that edge.
//   read side  - standard mode: rd_en=1 with empty=0 pops a word, which shows
//                on dout with valid=1 after the same edge. FWFT mode: valid=1
//                means dout already holds the head word, and rd_en=1
//                acknowledges (consumes) it at the edge. rd_en while empty is
//                dropped and reported by a one-cycle underflow pulse.
interface fifo_sync_param_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic [DATA_W-1:0] din;
  logic              wr_en;
  logic              rd_en;
  logic [DATA_W-1:0] dout;
  logic              valid;
  logic              empty;
  logic              full;
  logic              almost_full;
  logic              almost_empty;
  logic [ADDR_W:0]   data_count;
  logic              overflow;
  logic              underflow;

  // Producer/consumer side
  modport master (
    output din, wr_en, rd_en,
    input  dout, valid, empty, full, almost_full, almost_empty,
           data_count, overflow, underflow
  );

  // FIFO side
  modport slave (
    input  din, wr_en, rd_en,
    output dout, valid, empty, full, almost_full, almost_empty,
           data_count, overflow, underflow
  );
endinterface

// File: rtl/fifo_sync_param.sv
// Single-clock parametrised FIFO with occupancy count, programmable
// almost-full/almost-empty flags, overflow/underflow pulses and an optional
// first-word-fall-through output stage.
//
// data_count always counts every word held, including the word parked in the
// FWFT output stage, so full/almost flags mean the same thing in both modes.
module fifo_sync_param #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int AF_THRESH = 2**ADDR_W - 2,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 0
) (
  input  logic             clk,
  input  logic             srst,
  fifo_sync_param_if.slave bus
);

  localparam int              DEPTH     = 2**ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_CNT    = (ADDR_W+1)'(AF_THRESH);
  localparam logic [ADDR_W:0] AE_CNT    = (ADDR_W+1)'(AE_THRESH);
  localparam logic [ADDR_W:0] ONE_CNT   = (ADDR_W+1)'(1);

  // Storage (not reset)
  logic [DATA_W-1:0] mem [DEPTH];

  // Registered state
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count_q;
  logic [DATA_W-1:0] dout_q;
  logic              valid_q;
  logic              overflow_q;
  logic              underflow_q;

  // Combinational decode
  logic              full_c;
  logic              empty_c;
  logic              wr_accept;
  logic              rd_accept;
  logic              mem_rd;     // move mem[rd_ptr] into dout at this edge
  logic [ADDR_W:0]   mem_count;  // words still in the RAM (excludes FWFT stage)
  logic [ADDR_W:0]   count_d;
  logic              valid_d;

  // Readable/writable decode and request acceptance; a rejected write is
  // never rescued by a read in the same cycle because full comes from the
  // registered count.
  always_comb begin
    full_c = (count_q == DEPTH_CNT);
    if (FWFT != 0) begin
      empty_c = !valid_q;
    end else begin
      empty_c = (count_q == '0);
    end
    wr_accept = bus.wr_en && !full_c;
    rd_accept = bus.rd_en && !empty_c;
  end

  // Output-stage control and next occupancy. In FWFT mode the stage refills
  // from the RAM whenever it is empty or being consumed, giving back-to-back
  // words with no bubble; words written this edge are not yet visible to it.
  always_comb begin
    mem_count = count_q - (ADDR_W+1)'(valid_q);
    mem_rd    = rd_accept;
    valid_d   = rd_accept;
    if (FWFT != 0) begin
      mem_rd = (mem_count != '0) && (!valid_q || rd_accept);
      if (mem_rd) begin
        valid_d = 1'b1;
      end else if (rd_accept) begin
        valid_d = 1'b0;
      end else begin
        valid_d = valid_q;
      end
    end

    count_d = count_q;
    case ({wr_accept, rd_accept})
      2'b10:   count_d = count_q + ONE_CNT;
      2'b01:   count_d = count_q - ONE_CNT;
      default: count_d = count_q;
    endcase
  end

  // RAM write port; writes during reset are ignored.
  always_ff @(posedge clk) begin
    if (!srst && wr_accept) begin
      mem[wr_ptr] <= bus.din;
    end
  end

  // Pointers, count, output register and error pulses.
  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      dout_q      <= '0;
      valid_q     <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_accept) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (mem_rd) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
        dout_q <= mem[rd_ptr];
      end
      count_q     <= count_d;
      valid_q     <= valid_d;
      overflow_q  <= bus.wr_en && full_c;
      underflow_q <= bus.rd_en && empty_c;
    end
  end

  assign bus.dout         = dout_q;
  assign bus.valid        = valid_q;
  assign bus.empty        = empty_c;
  assign bus.full         = full_c;
  assign bus.data_count   = count_q;
  assign bus.almost_full  = (count_q >= AF_CNT);
  assign bus.almost_empty = (count_q <= AE_CNT);
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Bench for fifo_sync_param: one standard-mode and one FWFT instance,
// DATA_W=8, ADDR_W=4, AF=14, AE=2, sharing clk and srst.
module tb_fifo_sync_param;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int AF    = 14;
  localparam int AE    = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic srst;
  always #5 clk = ~clk;

  fifo_sync_param_if #(.DATA_W(DW), .ADDR_W(AW)) bus0 ();
  fifo_sync_param_if #(.DATA_W(DW), .ADDR_W(AW)) bus1 ();

  fifo_sync_param #(
    .DATA_W(DW), .ADDR_W(AW), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(0)
  ) dut_std (
    .clk (clk),
    .srst(srst),
    .bus (bus0)
  );

  fifo_sync_param #(
    .DATA_W(DW), .ADDR_W(AW), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1)
  ) dut_fwft (
    .clk (clk),
    .srst(srst),
    .bus (bus1)
  );

  // ---------------- scoreboard ----------------
  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [DW-1:0] exp_q[$];    // standard instance, expected read order
  logic [DW-1:0] exp_q1[$];   // FWFT instance, expected head order
  int            m_count;     // standard instance, expected occupancy
  logic [DW-1:0] m_dout;      // standard instance, expected dout

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  // Drives both instances for one cycle, then checks the standard instance
  // against the reference model.
  task automatic step(input logic wr0, input logic rd0, input logic [DW-1:0] d0,
                      input logic wr1, input logic rd1, input logic [DW-1:0] d1);
    logic e_ovf, e_unf, wacc, racc;
    e_ovf = wr0 && (m_count == DEPTH);
    e_unf = rd0 && (m_count == 0);
    wacc  = wr0 && !e_ovf;
    racc  = rd0 && !e_unf;
    if (racc) m_dout = exp_q.pop_front();
    if (wacc) exp_q.push_back(d0);
    m_count = m_count + (wacc ? 1 : 0) - (racc ? 1 : 0);

    bus0.wr_en = wr0; bus0.rd_en = rd0; bus0.din = d0;
    bus1.wr_en = wr1; bus1.rd_en = rd1; bus1.din = d1;
    tick();

    check("std valid",        32'(bus0.valid),        32'(racc));
    check("std dout",         32'(bus0.dout),         32'(m_dout));
    check("std data_count",   32'(bus0.data_count),   32'(m_count));
    check("std full",         32'(bus0.full),         32'(m_count == DEPTH));
    check("std empty",        32'(bus0.empty),        32'(m_count == 0));
    check("std almost_full",  32'(bus0.almost_full),  32'(m_count >= AF));
    check("std almost_empty", 32'(bus0.almost_empty), 32'(m_count <= AE));
    check("std overflow",     32'(bus0.overflow),     32'(e_ovf));
    check("std underflow",    32'(bus0.underflow),    32'(e_unf));
  endtask

  task automatic s0(input logic wr, input logic rd, input logic [DW-1:0] d);
    step(wr, rd, d, 1'b0, 1'b0, '0);
  endtask

  task automatic s1(input logic wr, input logic rd, input logic [DW-1:0] d);
    step(1'b0, 1'b0, '0, wr, rd, d);
  endtask

  task automatic check1(input string tag, input logic ev, input int ecnt,
                        input logic eempty, input logic efull);
    check({"fwft valid ", tag}, 32'(bus1.valid),      32'(ev));
    check({"fwft count ", tag}, 32'(bus1.data_count), 32'(ecnt));
    check({"fwft empty ", tag}, 32'(bus1.empty),      32'(eempty));
    check({"fwft full ", tag},  32'(bus1.full),       32'(efull));
  endtask

  task automatic check_reset_all(input string tag);
    check({"rst std dout ", tag},   32'(bus0.dout),         32'(0));
    check({"rst std valid ", tag},  32'(bus0.valid),        32'(0));
    check({"rst std empty ", tag},  32'(bus0.empty),        32'(1));
    check({"rst std full ", tag},   32'(bus0.full),         32'(0));
    check({"rst std count ", tag},  32'(bus0.data_count),   32'(0));
    check({"rst std ovf ", tag},    32'(bus0.overflow),     32'(0));
    check({"rst std unf ", tag},    32'(bus0.underflow),    32'(0));
    check({"rst std ae ", tag},     32'(bus0.almost_empty), 32'(1));
    check({"rst std af ", tag},     32'(bus0.almost_full),  32'(0));
    check({"rst fwft dout ", tag},  32'(bus1.dout),         32'(0));
    check({"rst fwft valid ", tag}, 32'(bus1.valid),        32'(0));
    check({"rst fwft empty ", tag}, 32'(bus1.empty),        32'(1));
    check({"rst fwft full ", tag},  32'(bus1.full),         32'(0));
    check({"rst fwft count ", tag}, 32'(bus1.data_count),   32'(0));
    check({"rst fwft ovf ", tag},   32'(bus1.overflow),     32'(0));
    check({"rst fwft unf ", tag},   32'(bus1.underflow),    32'(0));
    check({"rst fwft ae ", tag},    32'(bus1.almost_empty), 32'(1));
    check({"rst fwft af ", tag},    32'(bus1.almost_full),  32'(0));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          wr;
    logic          rd;
    logic [DW-1:0] din;
    int            e_count;
    logic          e_valid;
    logic [DW-1:0] e_dout;
    logic          e_ovf;
    logic          e_unf;
  } vec_t;

  localparam int NVEC = 35;
  vec_t vecs[NVEC];

  function automatic vec_t mk(input logic wr, input logic rd, input logic [DW-1:0] din,
                              input int cnt, input logic ev, input logic [DW-1:0] ed,
                              input logic eovf, input logic eunf);
    vec_t v;
    v.wr = wr; v.rd = rd; v.din = din;
    v.e_count = cnt; v.e_valid = ev; v.e_dout = ed;
    v.e_ovf = eovf; v.e_unf = eunf;
    return v;
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    int n;
    logic [DW-1:0] hd;

    // Fill: 0x01..0x10 then a rejected 17th write; drain in order; one
    // extra read into an empty FIFO; one idle cycle to see the pulse drop.
    n = 0;
    for (int i = 0; i < 17; i++) begin
      vecs[n] = mk(1'b1, 1'b0, 8'(i + 1), (i < 16) ? i + 1 : 16, 1'b0, 8'h00, i == 16, 1'b0);
      n++;
    end
    for (int i = 0; i < 16; i++) begin
      vecs[n] = mk(1'b0, 1'b1, 8'h00, 15 - i, 1'b1, 8'(i + 1), 1'b0, 1'b0);
      n++;
    end
    vecs[n] = mk(1'b0, 1'b1, 8'h00, 0, 1'b0, 8'h10, 1'b0, 1'b1); n++;
    vecs[n] = mk(1'b0, 1'b0, 8'h00, 0, 1'b0, 8'h10, 1'b0, 1'b0); n++;

    srst = 1'b1;
    bus0.wr_en = 1'b0; bus0.rd_en = 1'b0; bus0.din = '0;
    bus1.wr_en = 1'b0; bus1.rd_en = 1'b0; bus1.din = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_all("init");
    srst = 1'b0;

    // Table-driven fill/drain on the standard instance
    for (int i = 0; i < NVEC; i++) begin
      bus0.wr_en = vecs[i].wr; bus0.rd_en = vecs[i].rd; bus0.din = vecs[i].din;
      tick();
      check($sformatf("vec%0d count", i), 32'(bus0.data_count),   32'(vecs[i].e_count));
      check($sformatf("vec%0d valid", i), 32'(bus0.valid),        32'(vecs[i].e_valid));
      check($sformatf("vec%0d dout", i),  32'(bus0.dout),         32'(vecs[i].e_dout));
      check($sformatf("vec%0d full", i),  32'(bus0.full),         32'(vecs[i].e_count == DEPTH));
      check($sformatf("vec%0d empty", i), 32'(bus0.empty),        32'(vecs[i].e_count == 0));
      check($sformatf("vec%0d af", i),    32'(bus0.almost_full),  32'(vecs[i].e_count >= AF));
      check($sformatf("vec%0d ae", i),    32'(bus0.almost_empty), 32'(vecs[i].e_count <= AE));
      check($sformatf("vec%0d ovf", i),   32'(bus0.overflow),     32'(vecs[i].e_ovf));
      check($sformatf("vec%0d unf", i),   32'(bus0.underflow),    32'(vecs[i].e_unf));
    end
    bus0.wr_en = 1'b0; bus0.rd_en = 1'b0;
    m_count = 0;
    m_dout  = 8'h10;
    exp_q.delete();

    // Pointer wrap: 10 in, 10 out, then 20 writes interleaved with 10 reads
    for (int i = 0; i < 10; i++) s0(1'b1, 1'b0, 8'($urandom_range(0, 255)));
    for (int i = 0; i < 10; i++) s0(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 20; i++) s0(1'b1, 1'(i % 2), 8'($urandom_range(0, 255)));

    // Simultaneous read/write at count 5, 16 and 0
    for (int i = 0; i < 5; i++) s0(1'b0, 1'b1, 8'h00);
    check("count before rw@5", 32'(bus0.data_count), 32'(5));
    s0(1'b1, 1'b1, 8'($urandom_range(0, 255)));
    for (int i = 0; i < 11; i++) s0(1'b1, 1'b0, 8'($urandom_range(0, 255)));
    check("count before rw@16", 32'(bus0.data_count), 32'(16));
    s0(1'b1, 1'b1, 8'hEE);
    for (int i = 0; i < 15; i++) s0(1'b0, 1'b1, 8'h00);
    check("count before rw@0", 32'(bus0.data_count), 32'(0));
    s0(1'b1, 1'b1, 8'h77);
    s0(1'b0, 1'b1, 8'h00);

    // Random traffic
    for (int i = 0; i < 60; i++)
      s0(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));

    // FWFT: first word falls through one edge after it is written
    s1(1'b1, 1'b0, 8'hA5); exp_q1.push_back(8'hA5);
    check1("after A5 write", 1'b0, 1, 1'b1, 1'b0);
    s1(1'b1, 1'b0, 8'hB1); exp_q1.push_back(8'hB1);
    check1("after B1 write", 1'b1, 2, 1'b0, 1'b0);
    check("fwft dout A5", 32'(bus1.dout), 32'(8'hA5));
    s1(1'b1, 1'b0, 8'hB2); exp_q1.push_back(8'hB2);
    s1(1'b1, 1'b0, 8'hB3); exp_q1.push_back(8'hB3);
    check1("4 held", 1'b1, 4, 1'b0, 1'b0);

    // FWFT: continuous acknowledge, one word per cycle
    for (int k = 0; k < 4; k++) begin
      hd = exp_q1.pop_front();
      check($sformatf("fwft burst dout %0d", k),  32'(bus1.dout),  32'(hd));
      check($sformatf("fwft burst valid %0d", k), 32'(bus1.valid), 32'(1));
      s1(1'b0, 1'b1, 8'h00);
      check($sformatf("fwft burst count %0d", k), 32'(bus1.data_count), 32'(3 - k));
    end
    check1("drained", 1'b0, 0, 1'b1, 1'b0);

    // FWFT: read while empty
    s1(1'b0, 1'b1, 8'h00);
    check("fwft underflow pulse", 32'(bus1.underflow), 32'(1));
    s1(1'b0, 1'b0, 8'h00);
    check("fwft underflow clear", 32'(bus1.underflow), 32'(0));

    // FWFT: write and acknowledge together with one word held
    s1(1'b1, 1'b0, 8'hC7);
    s1(1'b0, 1'b0, 8'h00);
    check1("C7 held", 1'b1, 1, 1'b0, 1'b0);
    check("fwft dout C7", 32'(bus1.dout), 32'(8'hC7));
    s1(1'b1, 1'b1, 8'hD8);
    check1("C7 out D8 in", 1'b0, 1, 1'b1, 1'b0);
    s1(1'b0, 1'b0, 8'h00);
    check1("D8 head", 1'b1, 1, 1'b0, 1'b0);
    check("fwft dout D8", 32'(bus1.dout), 32'(8'hD8));
    s1(1'b0, 1'b1, 8'h00);
    check1("D8 consumed", 1'b0, 0, 1'b1, 1'b0);

    // FWFT: fill to DEPTH (stage counts as storage), then overflow
    for (int i = 0; i < DEPTH; i++) begin
      s1(1'b1, 1'b0, 8'(8'h40 + i));
      check($sformatf("fwft fill count %0d", i), 32'(bus1.data_count), 32'(i + 1));
      check($sformatf("fwft fill af %0d", i),    32'(bus1.almost_full),  32'((i + 1) >= AF));
      check($sformatf("fwft fill ae %0d", i),    32'(bus1.almost_empty), 32'((i + 1) <= AE));
    end
    s1(1'b1, 1'b0, 8'hEE);
    check1("full + overflow", 1'b1, 16, 1'b0, 1'b1);
    check("fwft overflow pulse", 32'(bus1.overflow), 32'(1));
    check("fwft dout head 0x40", 32'(bus1.dout), 32'(8'h40));

    // Mid-burst reset: standard instance at count 9 with wr_en held
    for (int k = 0; k < DEPTH && m_count > 0; k++) s0(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 9; i++) s0(1'b1, 1'b0, 8'(8'h90 + i));
    check("count before srst", 32'(bus0.data_count), 32'(9));
    srst = 1'b1;
    bus0.wr_en = 1'b1; bus0.rd_en = 1'b0; bus0.din = 8'h99;
    bus1.wr_en = 1'b1; bus1.rd_en = 1'b0; bus1.din = 8'h99;
    tick();
    check_reset_all("mid");
    srst = 1'b0;
    m_count = 0;
    m_dout  = '0;
    exp_q.delete();
    exp_q1.delete();

    // Round trip after reset
    s0(1'b1, 1'b0, 8'h3C);
    s0(1'b0, 1'b1, 8'h00);
    s1(1'b1, 1'b0, 8'h5A);
    s1(1'b0, 1'b0, 8'h00);
    check1("post-rst head", 1'b1, 1, 1'b0, 1'b0);
    check("fwft post-rst dout", 32'(bus1.dout), 32'(8'h5A));
    s1(1'b0, 1'b1, 8'h00);
    check1("post-rst drained", 1'b0, 0, 1'b1, 1'b0);

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
